// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bus bundle around the shared data-memory arbiter.
//   core_*  : core datapath load/store port (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   host_*  : host/debug port, same handshake, plus host_lock for burst ownership
//   mem_*   : single-port memory command (en/we/addr/wdata out) and read data in
// modport slave  : the arbiter's view
// modport master : the view of the requesters and the memory around the arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_lock;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata, core_stall,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata, core_stall,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core datapath and a
// host/debug port. At most one access is granted per cycle; the winner's command drives
// the memory in the grant cycle and read data returns to the winner one cycle later.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : dmem_arbiter_if.slave (core port, host port with lock, memory command)
module dmem_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int HOST_BURST_MAX = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(HOST_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(HOST_BURST_MAX);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  owner_e            last_gnt_r;   // owner of the previous cycle's grant
  owner_e            prio_r;       // round-robin pointer, only ever CORE or HOST
  owner_e            rd_owner_r;   // side whose read data arrives this cycle
  logic [CNT_W-1:0]  burst_cnt_r;
  logic [DATA_W-1:0] core_rdata_r;
  logic [DATA_W-1:0] host_rdata_r;

  logic              core_gnt_s;
  logic              host_gnt_s;
  logic              host_keep_s;
  logic              core_rvalid_s;
  logic              host_rvalid_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // A locked host keeps the memory only while its burst allowance lasts, so a
  // waiting core is never held off for more than HOST_BURST_MAX cycles.
  assign host_keep_s = bus.host_lock && (last_gnt_r == OWN_HOST) &&
                       (burst_cnt_r < BURST_LIMIT);

  // Grant selection from this cycle's requests and the registered arbitration state.
  always_comb begin
    core_gnt_s = 1'b0;
    host_gnt_s = 1'b0;
    if (reset) begin
      core_gnt_s = 1'b0;
      host_gnt_s = 1'b0;
    end else if (bus.core_req && bus.host_req) begin
      if (host_keep_s || (prio_r == OWN_HOST)) begin
        host_gnt_s = 1'b1;
      end else begin
        core_gnt_s = 1'b1;
      end
    end else if (bus.core_req) begin
      core_gnt_s = 1'b1;
    end else if (bus.host_req) begin
      host_gnt_s = 1'b1;
    end else begin
      core_gnt_s = 1'b0;
      host_gnt_s = 1'b0;
    end
  end

  // Memory command mux: the winner's fields, zero when nobody is granted.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    if (core_gnt_s) begin
      mem_we_s    = bus.core_we;
      mem_addr_s  = bus.core_addr;
      mem_wdata_s = bus.core_wdata;
    end else if (host_gnt_s) begin
      mem_we_s    = bus.host_we;
      mem_addr_s  = bus.host_addr;
      mem_wdata_s = bus.host_wdata;
    end else begin
      mem_we_s    = 1'b0;
      mem_addr_s  = {ADDR_W{1'b0}};
      mem_wdata_s = {DATA_W{1'b0}};
    end
  end

  // Arbitration state, read tagging and per-side read-data hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_r   <= OWN_IDLE;
      prio_r       <= OWN_CORE;
      rd_owner_r   <= OWN_IDLE;
      burst_cnt_r  <= {CNT_W{1'b0}};
      core_rdata_r <= {DATA_W{1'b0}};
      host_rdata_r <= {DATA_W{1'b0}};
    end else begin
      if (core_gnt_s) begin
        last_gnt_r <= OWN_CORE;
        prio_r     <= OWN_HOST;
      end else if (host_gnt_s) begin
        last_gnt_r <= OWN_HOST;
        prio_r     <= OWN_CORE;
      end else begin
        last_gnt_r <= OWN_IDLE;
      end

      if (host_gnt_s) begin
        if (burst_cnt_r < BURST_LIMIT) begin
          burst_cnt_r <= burst_cnt_r + CNT_W'(1);
        end
      end else begin
        burst_cnt_r <= {CNT_W{1'b0}};
      end

      if (core_gnt_s && !bus.core_we) begin
        rd_owner_r <= OWN_CORE;
      end else if (host_gnt_s && !bus.host_we) begin
        rd_owner_r <= OWN_HOST;
      end else begin
        rd_owner_r <= OWN_IDLE;
      end

      // Capture the returning data so each side's rdata holds its last value.
      case (rd_owner_r)
        OWN_CORE: core_rdata_r <= bus.mem_rdata;
        OWN_HOST: host_rdata_r <= bus.mem_rdata;
        default:  ;
      endcase
    end
  end

  assign core_rvalid_s = !reset && (rd_owner_r == OWN_CORE);
  assign host_rvalid_s = !reset && (rd_owner_r == OWN_HOST);

  assign bus.core_gnt    = core_gnt_s;
  assign bus.host_gnt    = host_gnt_s;
  assign bus.core_stall  = bus.core_req && !core_gnt_s;
  assign bus.core_rvalid = core_rvalid_s;
  assign bus.host_rvalid = host_rvalid_s;
  assign bus.core_rdata  = reset ? {DATA_W{1'b0}} :
                           (core_rvalid_s ? bus.mem_rdata : core_rdata_r);
  assign bus.host_rdata  = reset ? {DATA_W{1'b0}} :
                           (host_rvalid_s ? bus.mem_rdata : host_rdata_r);
  assign bus.mem_en      = core_gnt_s || host_gnt_s;
  assign bus.mem_we      = mem_we_s;
  assign bus.mem_addr    = mem_addr_s;
  assign bus.mem_wdata   = mem_wdata_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int BURST = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .HOST_BURST_MAX(BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory behind the arbiter: 1-cycle read latency, write in the command cycle.
  logic [7:0] tb_mem [256];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= tb_mem[bus.mem_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owned the last access, whose turn it is, how long the
  // host has been running, and which side gets read data next.
  logic [7:0] ref_mem [256];
  int         m_last;      // 0 none, 1 core, 2 host
  int         m_turn;      // 1 core, 2 host
  int         m_run;       // consecutive host grants
  int         m_rd;        // 0 none, 1 core, 2 host
  logic [7:0] m_rd_data;
  logic [7:0] m_core_hold;
  logic [7:0] m_host_hold;

  // Sampled DUT outputs of the last cycle, for directed checks.
  logic s_cg, s_hg, s_stall, s_crv;
  logic [7:0] s_crd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 0; m_turn = 1; m_run = 0; m_rd = 0;
    m_rd_data = 8'h00; m_core_hold = 8'h00; m_host_hold = 8'h00;
  endtask

  // One clock cycle: inputs already driven; check mid-cycle, then advance the model.
  task automatic cycle();
    int         wc;
    logic       ewe;
    logic [7:0] ea, ed;
    @(negedge clk);
    s_cg = bus.core_gnt; s_hg = bus.host_gnt; s_stall = bus.core_stall;
    s_crv = bus.core_rvalid; s_crd = bus.core_rdata;
    if (reset) begin
      check_val("rst_core_gnt",    32'(bus.core_gnt), 32'd0);
      check_val("rst_host_gnt",    32'(bus.host_gnt), 32'd0);
      check_val("rst_mem_en",      32'(bus.mem_en), 32'd0);
      check_val("rst_mem_we",      32'(bus.mem_we), 32'd0);
      check_val("rst_mem_addr",    32'(bus.mem_addr), 32'd0);
      check_val("rst_mem_wdata",   32'(bus.mem_wdata), 32'd0);
      check_val("rst_core_rvalid", 32'(bus.core_rvalid), 32'd0);
      check_val("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
      check_val("rst_core_rdata",  32'(bus.core_rdata), 32'd0);
      check_val("rst_host_rdata",  32'(bus.host_rdata), 32'd0);
      model_reset();
    end else begin
      wc = 0;
      if (bus.core_req && bus.host_req) begin
        if (bus.host_lock && m_last == 2 && m_run < BURST) wc = 2;
        else wc = m_turn;
      end else if (bus.core_req) begin
        wc = 1;
      end else if (bus.host_req) begin
        wc = 2;
      end
      ewe = (wc == 1) ? bus.core_we    : bus.host_we;
      ea  = (wc == 1) ? bus.core_addr  : bus.host_addr;
      ed  = (wc == 1) ? bus.core_wdata : bus.host_wdata;

      check_val("core_gnt",   32'(bus.core_gnt), 32'(wc == 1));
      check_val("host_gnt",   32'(bus.host_gnt), 32'(wc == 2));
      check_val("mem_en",     32'(bus.mem_en), 32'(wc != 0));
      check_val("core_stall", 32'(bus.core_stall), 32'(bus.core_req && wc != 1));
      if (wc != 0) begin
        check_val("mem_we",   32'(bus.mem_we), 32'(ewe));
        check_val("mem_addr", 32'(bus.mem_addr), 32'(ea));
        if (ewe) check_val("mem_wdata", 32'(bus.mem_wdata), 32'(ed));
      end
      check_val("core_rvalid", 32'(bus.core_rvalid), 32'(m_rd == 1));
      check_val("host_rvalid", 32'(bus.host_rvalid), 32'(m_rd == 2));
      check_val("core_rdata",  32'(bus.core_rdata), 32'((m_rd == 1) ? m_rd_data : m_core_hold));
      check_val("host_rdata",  32'(bus.host_rdata), 32'((m_rd == 2) ? m_rd_data : m_host_hold));

      if (m_rd == 1) m_core_hold = m_rd_data;
      if (m_rd == 2) m_host_hold = m_rd_data;
      m_rd = 0;
      if (wc != 0) begin
        if (ewe) ref_mem[ea] = ed;
        else begin
          m_rd = wc;
          m_rd_data = ref_mem[ea];
        end
      end
      m_run  = (wc == 2) ? ((m_run < BURST) ? m_run + 1 : m_run) : 0;
      if (wc == 1) m_turn = 2;
      if (wc == 2) m_turn = 1;
      m_last = wc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_core(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.core_req = req; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
  endtask

  task automatic drive_host(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d, input logic lk);
    bus.host_req = req; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d; bus.host_lock = lk;
  endtask

  logic [9:0] pat_h;
  logic [9:0] pat_s;

  initial begin
    model_reset();
    // Reset with both sides requesting writes.
    reset = 1'b1;
    drive_core(1'b1, 1'b1, 8'h01, 8'hA1);
    drive_host(1'b1, 1'b1, 8'h02, 8'hB2, 1'b0);
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    check_val("t1_first_core_gnt", 32'(s_cg), 32'd1);
    drive_core(1'b0, 1'b0, 8'h00, 8'h00);
    cycle();
    drive_host(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle();

    // Preload every location through the host port.
    for (int a = 0; a < 256; a++) begin
      drive_host(1'b1, 1'b1, 8'(a), 8'($urandom_range(0, 255)), 1'b0);
      cycle();
    end
    drive_host(1'b1, 1'b1, 8'h80, 8'h5A, 1'b0);
    cycle();
    drive_host(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Core read of 0x80 with the host idle.
    drive_core(1'b1, 1'b0, 8'h80, 8'h00);
    cycle();
    check_val("t2_core_gnt", 32'(s_cg), 32'd1);
    drive_core(1'b0, 1'b0, 8'h00, 8'h00);
    cycle();
    check_val("t2_rvalid", 32'(s_crv), 32'd1);
    check_val("t2_rdata",  32'(s_crd), 32'h5A);

    // Round-robin with both sides requesting, no lock.
    reset = 1'b1; cycle(); reset = 1'b0;
    drive_core(1'b1, 1'b0, 8'h20, 8'h00);
    drive_host(1'b1, 1'b0, 8'h21, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      pat_h[i] = s_hg;
      pat_s[i] = s_stall;
    end
    check_val("t3_host_pattern",  32'(pat_h[5:0]), 32'(6'b101010));
    check_val("t3_stall_pattern", 32'(pat_s[5:0]), 32'(6'b101010));

    // Locked host bursts, bounded by the burst limit.
    reset = 1'b1; cycle(); reset = 1'b0;
    drive_host(1'b1, 1'b0, 8'h22, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      pat_h[i] = s_hg;
    end
    check_val("t4_host_pattern", 32'(pat_h), 32'(10'b1111011110));
    drive_core(1'b0, 1'b0, 8'h00, 8'h00);
    drive_host(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Host write then core read of the same address.
    reset = 1'b1; cycle(); reset = 1'b0;
    drive_host(1'b1, 1'b1, 8'h10, 8'h33, 1'b0);
    cycle();
    drive_host(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive_core(1'b1, 1'b0, 8'h10, 8'h00);
    cycle();
    drive_core(1'b0, 1'b0, 8'h00, 8'h00);
    cycle();
    check_val("t5_rvalid", 32'(s_crv), 32'd1);
    check_val("t5_rdata",  32'(s_crd), 32'h33);

    // Reset right after a granted read suppresses its rvalid.
    drive_core(1'b1, 1'b0, 8'h10, 8'h00);
    cycle();
    check_val("t6_core_gnt", 32'(s_cg), 32'd1);
    drive_core(1'b0, 1'b0, 8'h00, 8'h00);
    reset = 1'b1;
    cycle();
    check_val("t6_rvalid_in_reset", 32'(s_crv), 32'd0);
    cycle();
    reset = 1'b0;
    drive_core(1'b1, 1'b1, 8'h11, 8'h44);
    drive_host(1'b1, 1'b1, 8'h12, 8'h55, 1'b0);
    cycle();
    check_val("t6_rvalid_after", 32'(s_crv), 32'd0);
    check_val("t6_core_first",   32'(s_cg), 32'd1);
    drive_core(1'b0, 1'b0, 8'h00, 8'h00);
    drive_host(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle();

    // Randomized traffic; a waiting requester holds its command or drops it.
    for (int i = 0; i < 600; i++) begin
      if (bus.core_req && !s_cg) begin
        if ($urandom_range(0, 7) == 0) bus.core_req = 1'b0;
      end else begin
        drive_core(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end
      if (bus.host_req && !s_hg) begin
        if ($urandom_range(0, 7) == 0) bus.host_req = 1'b0;
      end else begin
        drive_host(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b0);
      end
      bus.host_lock = 1'($urandom_range(0, 3) != 0);
      reset = 1'($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
